// File: rtl/hilo_muldiv_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hilo_muldiv_unit_pkg                                       |
// | Description : Shared op encodings and FSM state type for the HI/LO       |
// |               multiply/divide unit.                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package hilo_muldiv_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MOVE = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DZ   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_unit_muldiv_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hilo_muldiv_unit_muldiv_step                               |
// | Description : muldiv_step - one radix-2 iteration, combinational.        |
// |               mult: next = 2*partial + (bit ? operand : 0)               |
// |               div : restoring step, shifts the dividend bit in and       |
// |                     subtracts the divisor when it fits (o_q_bit=1).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hilo_muldiv_unit_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div_mode,
  input  logic [2*WIDTH-1:0] i_partial,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic               i_bit,
  output logic [2*WIDTH-1:0] o_next,
  output logic               o_q_bit
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] w_shifted;
  logic [PW-1:0] w_addend;
  logic [PW-1:0] w_trial;

  // Single shift-add (mult) or shift-compare-subtract (div) iteration
  always_comb begin
    w_shifted = (i_partial << 1) | {{(PW-1){1'b0}}, i_div_mode & i_bit};
    w_addend  = {{WIDTH{1'b0}}, i_operand};
    w_trial   = w_shifted - w_addend;
    o_q_bit   = 1'b0;
    o_next    = w_shifted;
    if (i_div_mode) begin
      if (w_shifted >= w_addend) begin
        o_q_bit = 1'b1;
        o_next  = w_trial;
      end
    end else if (i_bit) begin
      o_next = w_shifted + w_addend;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hilo_muldiv_unit                                           |
// | Description : Iterative multiply/divide unit owning HI/LO, with a        |
// |               start/busy/done handshake. Optional macro HILO_MADD_EN     |
// |               enables MADD/MSUB accumulation into {HI,LO}.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  // opa: multiplicand / divisor magnitude; opb: multiplier / dividend bits,
  // shifted left each step so it ends up holding the quotient.
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             done_q, done_d, dz_q, dz_d;

  logic             w_div_mode, w_q_bit, w_accept;
  logic [PW-1:0]    w_step_next, w_prod;
  logic             w_is_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_quot, w_rem;

  assign w_div_mode  = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign busy        = (state_q == S_RUN) || (state_q == S_FIX) || (state_q == S_DZ);
  assign w_accept    = start && !busy;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  hilo_muldiv_unit_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div_mode (w_div_mode),
    .i_partial  (acc_q),
    .i_operand  (opa_q),
    .i_bit      (opb_q[WIDTH-1]),
    .o_next     (w_step_next),
    .o_q_bit    (w_q_bit)
  );

  // Operand magnitudes at accept time and sign-corrected results at FIX time
  always_comb begin
    w_is_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    w_a_neg     = w_is_signed && a[WIDTH-1];
    w_b_neg     = w_is_signed && b[WIDTH-1];
    w_a_mag     = w_a_neg ? -a : a;
    w_b_mag     = w_b_neg ? -b : b;
    w_prod      = qneg_q ? -acc_q : acc_q;
    w_quot      = qneg_q ? -opb_q : opb_q;
    w_rem       = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  // Next-state, iteration datapath and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;

    case (state_q)
      S_RUN: begin
        acc_d = w_step_next;
        opb_d = {opb_q[WIDTH-2:0], w_q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (w_div_mode) begin
          lo_d = w_quot;
          hi_d = w_rem;
        end else begin
`ifdef HILO_MADD_EN
          if (op_q == OP_MADD)      {hi_d, lo_d} = {hi_q, lo_q} + w_prod;
          else if (op_q == OP_MSUB) {hi_d, lo_d} = {hi_q, lo_q} - w_prod;
          else                      {hi_d, lo_d} = w_prod;
`else
          {hi_d, lo_d} = w_prod;
`endif
        end
      end
      S_DZ: begin
        state_d = S_IDLE;
        hi_d    = opb_q;
        lo_d    = '1;
        done_d  = 1'b1;
        dz_d    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Accepted in IDLE or MOVE; the RUN/FIX/DZ branches above never see it
    if (w_accept) begin
      op_d   = op;
      opa_d  = w_b_mag;
      opb_d  = w_a_mag;
      acc_d  = '0;
      cnt_d  = '0;
      qneg_d = w_a_neg ^ w_b_neg;
      rneg_d = w_a_neg;
      case (op)
        OP_MTHI: begin
          hi_d    = a;
          done_d  = 1'b1;
          state_d = S_MOVE;
        end
        OP_MTLO: begin
          lo_d    = a;
          done_d  = 1'b1;
          state_d = S_MOVE;
        end
        OP_DIV, OP_DIVU: begin
          if (b == '0) begin
            opb_d   = a;
            state_d = S_DZ;
          end else begin
            state_d = S_RUN;
          end
        end
        OP_MULT, OP_MULTU: state_d = S_RUN;
`ifdef HILO_MADD_EN
        OP_MADD, OP_MSUB:  state_d = S_RUN;
`endif
        default: ;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hilo_muldiv_unit                                        |
// | Description : Self-checking bench for hilo_muldiv_unit (WIDTH=32).       |
// |               Honours HILO_MADD_EN when defined.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hilo_muldiv_unit;

  localparam int W       = 32;
  localparam int RUN_LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Architectural HI/LO as the reference model sees them
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t tbl[12];

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; lat = edges after accept until done
  // is visible (-1 = no done expected at all).
  task automatic model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output logic edz);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [2*W-1:0]  p;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    ua  = {32'd0, av};
    ub  = {32'd0, bv};
    edz = 1'b0;
    lat = RUN_LAT;
    case (o)
      3'd0: begin p = sa * sb; {m_hi, m_lo} = p; end
      3'd1: begin p = ua * ub; {m_hi, m_lo} = p; end
      3'd2, 3'd3: begin
        if (bv == '0) begin
          m_hi = av; m_lo = '1; edz = 1'b1; lat = 1;
        end else if (o == 3'd2) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[W-1:0]; m_hi = r[W-1:0];
        end else begin
          uq = ua / ub; ur = ua % ub;
          m_lo = uq[W-1:0]; m_hi = ur[W-1:0];
        end
      end
      3'd4: begin m_hi = av; lat = 0; end
      3'd5: begin m_lo = av; lat = 0; end
      default: begin
`ifdef HILO_MADD_EN
        p = sa * sb;
        if (o == 3'd6) {m_hi, m_lo} = {m_hi, m_lo} + p;
        else           {m_hi, m_lo} = {m_hi, m_lo} - p;
`else
        lat = -1;
`endif
      end
    endcase
  endtask

  // Issue one op, scramble the inputs after accept, wait for done and check
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int got);
    int           lat;
    logic         edz;
    logic [W-1:0] old_hi, old_lo;
    bit           leak, busy_bad, seen;
    old_hi = m_hi;
    old_lo = m_lo;
    model(o, av, bv, lat, edz);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    got = 0; leak = 0; busy_bad = 0; seen = 0;
    if (lat < 0) begin
      repeat (RUN_LAT + 4) begin
        if (done || busy) seen = 1;
        @(posedge clk); #1;
      end
      chk("noop_quiet", 64'(seen), 64'(0));
      chk("noop_hi", 64'(hi), 64'(old_hi));
      chk("noop_lo", 64'(lo), 64'(old_lo));
      got = -1;
      return;
    end
    while (!done && got < 4 * RUN_LAT) begin
      if (busy !== 1'b1) busy_bad = 1;
      if (hi !== old_hi || lo !== old_lo) leak = 1;
      @(posedge clk); #1;
      got++;
    end
    chk($sformatf("latency op%0d", o), 64'(got), 64'(lat));
    chk("busy_in_flight", 64'(busy_bad), 64'(0));
    chk("no_early_update", 64'(leak), 64'(0));
    chk("busy_at_done", 64'(busy), 64'(0));
    chk($sformatf("hi op%0d", o), 64'(hi), 64'(m_hi));
    chk($sformatf("lo op%0d", o), 64'(lo), 64'(m_lo));
    chk("div_by_zero", 64'(div_by_zero), 64'(edz));
  endtask

  initial begin
    int got;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;

    tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    tbl[1]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    tbl[3]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33};
    tbl[4]  = '{3'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1};
    tbl[5]  = '{3'd4, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 0};
    tbl[6]  = '{3'd5, 32'h1234,     32'd0,        32'hDEADBEEF, 32'h1234,     1'b0, 0};
    tbl[7]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    tbl[8]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    tbl[9]  = '{3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1};
    tbl[10] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
    tbl[11] = '{3'd3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 33};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_dz",   64'(div_by_zero), 64'(0));
    chk("reset_hi",   64'(hi), 64'(0));
    chk("reset_lo",   64'(lo), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, got);
      chk($sformatf("tbl%0d_lat", i), 64'(got), 64'(tbl[i].lat));
      chk($sformatf("tbl%0d_hi", i),  64'(hi), 64'(tbl[i].hi));
      chk($sformatf("tbl%0d_lo", i),  64'(lo), 64'(tbl[i].lo));
      chk($sformatf("tbl%0d_dz", i),  64'(div_by_zero), 64'(tbl[i].dz));
    end

    // done / div_by_zero are single-cycle pulses; HI/LO hold afterwards
    do_op(3'd2, 32'd9, 32'd0, got);
    @(posedge clk); #1;
    chk("done_pulse_width", 64'(done), 64'(0));
    chk("dz_pulse_width",   64'(div_by_zero), 64'(0));
    chk("hold_hi",          64'(hi), 64'(32'd9));

    // Back-to-back MTHI / MTLO: busy stays low, two done pulses
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hDEADBEEF; b = '0;
    @(posedge clk); #1;
    chk("mthi_busy", 64'(busy), 64'(0));
    chk("mthi_done", 64'(done), 64'(1));
    chk("mthi_hi",   64'(hi), 64'(32'hDEADBEEF));
    @(negedge clk);
    op = 3'd5; a = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_busy", 64'(busy), 64'(0));
    chk("mtlo_done", 64'(done), 64'(1));
    chk("mtlo_lo",   64'(lo), 64'(32'h1234));
    chk("mtlo_hi",   64'(hi), 64'(32'hDEADBEEF));
    @(posedge clk); #1;
    chk("move_done_drop", 64'(done), 64'(0));
    m_hi = 32'hDEADBEEF;
    m_lo = 32'h1234;

    // Reset aborts a MULTU in flight
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = '1; b = '1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_dz",   64'(div_by_zero), 64'(0));
    chk("abort_hi",   64'(hi), 64'(0));
    chk("abort_lo",   64'(lo), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #1;
    chk("abort_stays_idle", 64'(busy), 64'(0));

    // Fresh MULTU 2x3 with a start pulsed while busy (must be dropped)
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    repeat (5) begin @(posedge clk); #1; got++; end
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h55;
    @(posedge clk); #1;
    start = 1'b0;
    got++;
    while (!done && got < 4 * RUN_LAT) begin @(posedge clk); #1; got++; end
    chk("ignore_lat", 64'(got), 64'(RUN_LAT));
    chk("ignore_hi",  64'(hi), 64'(0));
    chk("ignore_lo",  64'(lo), 64'(6));
    @(posedge clk); #1;
    chk("ignore_not_queued", 64'(done), 64'(0));
    chk("ignore_hi_after",   64'(hi), 64'(0));
    m_lo = 32'd6;

`ifdef HILO_MADD_EN
    do_op(3'd5, 32'd10, 32'd0, got);
    do_op(3'd6, 32'd4, 32'd5, got);
    chk("madd_hi", 64'(hi), 64'(0));
    chk("madd_lo", 64'(lo), 64'(30));
    do_op(3'd7, 32'd8, 32'd4, got);
    chk("msub_hi", 64'(hi), 64'(32'hFFFFFFFF));
    chk("msub_lo", 64'(lo), 64'(32'hFFFFFFFE));
`else
    do_op(3'd6, 32'd4, 32'd5, got);
    chk("madd_noop", 64'(got), 64'(-1));
    do_op(3'd7, 32'd8, 32'd4, got);
    chk("msub_noop", 64'(got), 64'(-1));
`endif

    // Randomised ops against the model
    for (int n = 0; n < 40; n++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = rb & 32'h000000FF;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) ra = ra & 32'h0000FFFF;
      do_op(ro, ra, rb, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
